// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, op codes and control-word bit indices for alu_sequencer
package alu_seq_pkg;

  localparam int C_W = 11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int C_LOADQ = 0;   // A<=0, Q<=inbus, Q-1<=0
  localparam int C_LOADM = 1;   // M<=inbus
  localparam int C_ADD   = 2;   // A<=A+M
  localparam int C_SUB   = 3;   // A<=A-M
  localparam int C_SHL   = 4;   // shift A:Q left
  localparam int C_SETQ  = 5;   // Q[0]<=~A[msb]
  localparam int C_OUTA  = 6;   // outbus<=A
  localparam int C_OUTQ  = 7;   // outbus<=Q
  localparam int C_LOADA = 8;   // A<=inbus
  localparam int C_ASR   = 9;   // arithmetic shift right A:Q:Q-1
  localparam int C_RSV   = 10;  // reserved, never driven high

  typedef enum logic [3:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    EXEC,
    MUL_TEST,
    MUL_SHIFT,
    DIV_SHIFT,
    DIV_ADDSUB,
    DIV_SETQ,
    DIV_CORR,
    OUT1,
    OUT2,
    ERR
  } state_e;

endpackage

// File: rtl/alu_seq_iter_counter.sv
// rtl/alu_seq_iter_counter.sv - modulo-WIDTH iteration counter with registered terminal flag
module alu_seq_iter_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  // Count iterations; last is precomputed so the FSM sees a flop, not a compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      last  <= 1'b0;
    end else if (inc) begin
      if (last) begin
        count <= '0;
        last  <= 1'b0;
      end else begin
        count <= count + 1'b1;
        last  <= ((count + 1'b1) == LAST_VAL);
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle add/sub/Booth mul/non-restoring div sequencer; divide enabled by ALU_SEQ_DIV_EN
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op_codes,
  input  logic           q_zero,
  input  logic           q_minus_one,
  input  logic           a_msb,
  input  logic           m_zero,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [C_W-1:0] c
);

  state_e     state, state_n;
  logic [1:0] op_r;
  logic       cnt_inc;
  logic       cnt_last;

`ifdef ALU_SEQ_DIV_EN
  logic       sgn;
`else
  logic       unused_div_inputs;
  assign unused_div_inputs = a_msb ^ m_zero;
`endif

  assign cnt_inc = (state == MUL_SHIFT) || (state == DIV_SETQ);

  alu_seq_iter_counter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Operation is latched once at acceptance so later op_codes changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         op_r <= OP_ADD;
    else if (state == IDLE && start)  op_r <= op_codes;
  end

`ifdef ALU_SEQ_DIV_EN
  // Sign of the partial remainder before the shift picks add or subtract next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    sgn <= 1'b0;
    else if (state == DIV_SHIFT) sgn <= a_msb;
  end
`endif

  // Next-state and control-word decode.
  always_comb begin
    state_n = state;
    c       = '0;
    busy    = (state != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = LOAD_X;
      end
      LOAD_X: begin
        if (!op_r[1]) c[C_LOADA] = 1'b1;
        else          c[C_LOADQ] = 1'b1;
        state_n = LOAD_Y;
      end
      LOAD_Y: begin
        c[C_LOADM] = 1'b1;
        case (op_r)
          OP_MUL: state_n = MUL_TEST;
`ifdef ALU_SEQ_DIV_EN
          OP_DIV: state_n = m_zero ? ERR : DIV_SHIFT;
`else
          OP_DIV: state_n = ERR;
`endif
          default: state_n = EXEC;
        endcase
      end
      EXEC: begin
        if (op_r == OP_SUB) c[C_SUB] = 1'b1;
        else                c[C_ADD] = 1'b1;
        state_n = OUT1;
      end
      MUL_TEST: begin
        if ({q_zero, q_minus_one} == 2'b01) c[C_ADD] = 1'b1;
        if ({q_zero, q_minus_one} == 2'b10) c[C_SUB] = 1'b1;
        state_n = MUL_SHIFT;
      end
      MUL_SHIFT: begin
        c[C_ASR] = 1'b1;
        state_n  = cnt_last ? OUT1 : MUL_TEST;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV_SHIFT: begin
        c[C_SHL] = 1'b1;
        state_n  = DIV_ADDSUB;
      end
      DIV_ADDSUB: begin
        if (sgn) c[C_ADD] = 1'b1;
        else     c[C_SUB] = 1'b1;
        state_n = DIV_SETQ;
      end
      DIV_SETQ: begin
        c[C_SETQ] = 1'b1;
        state_n   = cnt_last ? DIV_CORR : DIV_SHIFT;
      end
      DIV_CORR: begin
        if (a_msb) c[C_ADD] = 1'b1;
        state_n = OUT1;
      end
`endif
      OUT1: begin
        if (op_r == OP_DIV) c[C_OUTQ] = 1'b1;
        else                c[C_OUTA] = 1'b1;
        if (!op_r[1]) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = OUT2;
        end
      end
      OUT2: begin
        if (op_r == OP_MUL) c[C_OUTQ] = 1'b1;
        else                c[C_OUTA] = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural datapath
module tb_alu_sequencer;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] q;
    logic       q1;
    logic [7:0] m;
  } dp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  inbus;
  logic        busy, done, err;
  logic [10:0] c;
  dp_t         dp8 = '0;
  logic        m_zero8;

  logic        start5;
  logic [1:0]  op5 = 2'b10;
  logic [7:0]  inbus5;
  logic        busy5, done5, err5;
  logic [10:0] c5w;
  dp_t         dp5 = '0;
  logic        m_zero5;

  int          tests = 0;
  int          fails = 0;
  logic [10:0] hist [64];

  always #5 clk = ~clk;

  function automatic dp_t dp_step(input dp_t s, input int w, input logic [7:0] inb, input logic [10:0] cw);
    dp_t        n;
    logic [7:0] mask;
    n    = s;
    mask = 8'((1 << w) - 1);
    if (cw[0]) begin n.a = '0; n.q = inb & mask; n.q1 = 1'b0; end
    if (cw[1]) n.m = inb & mask;
    if (cw[8]) n.a = inb & mask;
    if (cw[2]) n.a = (s.a + s.m) & mask;
    if (cw[3]) n.a = (s.a - s.m) & mask;
    if (cw[4]) begin
      n.a = ((s.a << 1) | {7'd0, s.q[w-1]}) & mask;
      n.q = (s.q << 1) & mask;
    end
    if (cw[5]) n.q[0] = ~s.a[w-1];
    if (cw[9]) begin
      n.q1 = s.q[0];
      n.q  = ((s.q >> 1) | ({7'd0, s.a[0]} << (w - 1))) & mask;
      n.a  = (s.a >> 1) | (s.a & (8'd1 << (w - 1)));
    end
    return n;
  endfunction

  // Datapath models: registers update on the same edge the sequencer advances.
  always_ff @(posedge clk) dp8 <= dp_step(dp8, 8, inbus, c);
  always_ff @(posedge clk) dp5 <= dp_step(dp5, 5, inbus5, c5w);

  assign m_zero8 = ((c[1] ? inbus : dp8.m) == 8'd0);
  assign m_zero5 = ((c5w[1] ? (inbus5 & 8'h1f) : dp5.m) == 8'd0);

  alu_sequencer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_codes    (op),
    .q_zero      (dp8.q[0]),
    .q_minus_one (dp8.q1),
    .a_msb       (dp8.a[7]),
    .m_zero      (m_zero8),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .c           (c)
  );

  alu_sequencer #(.WIDTH(5)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .start       (start5),
    .op_codes    (op5),
    .q_zero      (dp5.q[0]),
    .q_minus_one (dp5.q1),
    .a_msb       (dp5.a[4]),
    .m_zero      (m_zero5),
    .busy        (busy5),
    .done        (done5),
    .err         (err5),
    .c           (c5w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] opc, input logic [7:0] x, input logic [7:0] y,
                        input int exp_cyc, input logic [10:0] exp_c1, input logic exp_err,
                        input int exp_nout, input logic [7:0] exp_o1, input logic [7:0] exp_o2,
                        input int exp_nadd, input int exp_nsub, input logic [10:0] exp_cdone);
    int          nadd = 0, nsub = 0, nout = 0, done_cyc = 0;
    logic [7:0]  o1 = '0, o2 = '0, outv;
    logic        errv = 1'b0, inv_ok = 1'b1, divseen = 1'b0, busy_after;
    logic [10:0] c_done = '0;
    @(negedge clk);
    start = 1'b1;
    op    = opc;
    @(negedge clk);
    op    = ~opc;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      inbus = (cyc == 1) ? x : y;
      start = (cyc == 2);
      hist[cyc] = c;
      if (c[2]) nadd++;
      if (c[3]) nsub++;
      if (c[4] || c[5]) divseen = 1'b1;
      if (c[10] || (c[2] && c[3]) || !busy) inv_ok = 1'b0;
      if (c[6] || c[7]) begin
        outv = c[6] ? dp8.a : dp8.q;
        if (nout == 0) o1 = outv;
        else           o2 = outv;
        nout++;
      end
      if (done) begin
        done_cyc = cyc;
        errv     = err;
        c_done   = c;
        start    = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = busy;
    start      = 1'b0;
    chk({tag, ".done_cycle"}, done_cyc, exp_cyc);
    chk({tag, ".c_cycle1"}, {21'd0, hist[1]}, {21'd0, exp_c1});
    chk({tag, ".c_cycle2"}, {21'd0, hist[2]}, 32'h002);
    chk({tag, ".err"}, {31'd0, errv}, {31'd0, exp_err});
    chk({tag, ".c_done"}, {21'd0, c_done}, {21'd0, exp_cdone});
    chk({tag, ".n_out"}, nout, exp_nout);
    if (exp_nout > 0) chk({tag, ".out1"}, {24'd0, o1}, {24'd0, exp_o1});
    if (exp_nout > 1) chk({tag, ".out2"}, {24'd0, o2}, {24'd0, exp_o2});
    chk({tag, ".n_add"}, nadd, exp_nadd);
    chk({tag, ".n_sub"}, nsub, exp_nsub);
    chk({tag, ".div_ops"}, {31'd0, divseen}, {31'd0, (opc == 2'b11) && !exp_err});
    chk({tag, ".invariants"}, {31'd0, inv_ok}, 32'd1);
    chk({tag, ".busy_after"}, {31'd0, busy_after}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc;
    int          n5;
    logic [7:0]  p1, p2;
    rst    = 1'b0;
    start  = 1'b1;
    op     = 2'b10;
    inbus  = '0;
    start5 = 1'b0;
    inbus5 = '0;
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);
    chk("reset.c", {21'd0, c}, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset.hold_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst   = 1'b1;

    run_op("add", 2'b00, 8'd25, 8'd17, 4, 11'h100, 1'b0, 1, 8'd42, 8'd0, 1, 0, 11'h040);
    run_op("sub", 2'b01, 8'd10, 8'd30, 4, 11'h100, 1'b0, 1, 8'hEC, 8'd0, 0, 1, 11'h040);
    run_op("mul_7xm3", 2'b10, 8'h07, 8'hFD, 20, 11'h001, 1'b0, 2, 8'hFF, 8'hEB, 1, 1, 11'h080);
    run_op("mul_m3x7", 2'b10, 8'hFD, 8'h07, 20, 11'h001, 1'b0, 2, 8'hFF, 8'hEB, 1, 2, 11'h080);
`ifdef ALU_SEQ_DIV_EN
    run_op("div_100_7", 2'b11, 8'd100, 8'd7, 29, 11'h001, 1'b0, 2, 8'd14, 8'd2, 5, 4, 11'h040);
    chk("div_100_7.corr_add", {31'd0, hist[27][2]}, 32'd1);
    chk("div_100_7.out1_word", {21'd0, hist[28]}, 32'h080);
`else
    run_op("div_disabled", 2'b11, 8'd100, 8'd5, 3, 11'h001, 1'b1, 0, 8'd0, 8'd0, 0, 0, 11'h000);
`endif
    run_op("div_by_zero", 2'b11, 8'd5, 8'd0, 3, 11'h001, 1'b1, 0, 8'd0, 8'd0, 0, 0, 11'h000);

    // Abort a multiply mid-flight with reset.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    inbus = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.err", {31'd0, err}, 32'd0);
    chk("abort.c", {21'd0, c}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_reset_add", 2'b00, 8'd25, 8'd17, 4, 11'h100, 1'b0, 1, 8'd42, 8'd0, 1, 0, 11'h040);
    run_op("post_reset_mul", 2'b10, 8'h07, 8'hFD, 20, 11'h001, 1'b0, 2, 8'hFF, 8'hEB, 1, 1, 11'h080);

    // WIDTH=5 multiply 3*3.
    dc = 0;
    n5 = 0;
    p1 = '0;
    p2 = '0;
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    inbus5 = 8'd3;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (c5w[6] || c5w[7]) begin
        if (n5 == 0) p1 = c5w[6] ? dp5.a : dp5.q;
        else         p2 = c5w[6] ? dp5.a : dp5.q;
        n5++;
      end
      if (done5) begin
        dc = cyc;
        chk("w5.err", {31'd0, err5}, 32'd0);
        break;
      end
      @(negedge clk);
    end
    chk("w5.done_cycle", dc, 14);
    chk("w5.prod_hi", {24'd0, p1}, 32'd0);
    chk("w5.prod_lo", {24'd0, p2}, 32'd9);
    @(negedge clk);
    chk("w5.busy_after", {31'd0, busy5}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Parametrised multi-cycle sequencer for the shared-register ALU datapath (A, Q, Q-1, M). It replaces the fixed 8-bit three-phase control unit with a single encoded FSM, an internal iteration counter sized from WIDTH, a busy/done handshake and divide-by-zero detection. It drives an 11-bit one-hot-per-micro-op control word into the datapath and supports add, subtract, Booth radix-2 multiply and non-restoring divide.

## Interface
- WIDTH, 8: operand width in bits; ≥2, need not be a power of two
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  operation request; sampled only in IDLE
- op_codes  input  2  00 add, 01 sub, 10 mul, 11 div; captured with start
- q_zero  input  1  datapath Q[0]
- q_minus_one  input  1  datapath Q-1 bit
- a_msb  input  1  datapath A[WIDTH-1]
- m_zero  input  1  datapath M == 0
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in final cycle of an operation
- err  output  1  one-cycle pulse with done on a rejected division
- c  output  11  micro-op word: c0 A<=0,Q<=inbus,Q-1<=0; c1 M<=inbus; c2 A<=A+M; c3 A<=A-M; c4 shift A:Q left; c5 Q[0]<=~a_msb; c6 outbus<=A; c7 outbus<=Q; c8 A<=inbus; c9 arithmetic shift right A:Q:Q-1; c10 reserved, always 0

## Operation
- States: IDLE, LOAD_X, LOAD_Y, EXEC, MUL_TEST, MUL_SHIFT, DIV_SHIFT, DIV_ADDSUB, DIV_SETQ, DIV_CORR, OUT1, OUT2, ERR.
- IDLE: start=1 latches op_codes into op_r, goes to LOAD_X; else stays.
- LOAD_X: c8 for add/sub, c0 for mul/div. LOAD_Y: c1. Next: add/sub→EXEC; mul→MUL_TEST; div→ERR if m_zero, else DIV_SHIFT.
- EXEC: c2 (add) or c3 (sub) → OUT1.
- MUL_TEST: {q_zero,q_minus_one}=01 → c2; 10 → c3; else none. → MUL_SHIFT.
- MUL_SHIFT: c9; iteration counter increments; at count WIDTH-1 counter wraps to 0, → OUT1; else → MUL_TEST.
- DIV_SHIFT: c4; sign flag sgn<=a_msb (value before shift). → DIV_ADDSUB.
- DIV_ADDSUB: sgn=1 → c2, else c3. → DIV_SETQ.
- DIV_SETQ: c5; counter increments; at WIDTH-1 wraps to 0, → DIV_CORR; else → DIV_SHIFT.
- DIV_CORR: c2 iff a_msb=1 (remainder correction). → OUT1.
- OUT1: add/sub/mul c6; div c7. add/sub: done=1, → IDLE. mul/div → OUT2.
- OUT2: mul c7; div c6. done=1, → IDLE.
- ERR: done=1, err=1, c=0, → IDLE.
- c2/c3 in MUL_TEST, DIV_CORR depend combinationally on datapath inputs; all other outputs decode from state and op_r only. At most one of c2/c3 high in any cycle.
- start outside IDLE ignored; op_codes changes after capture ignored.

## Timing
- Reset (rst=0, any time incl. mid-operation): state IDLE, counter 0, sgn 0, op_r 00; busy=0, done=0, err=0, c=0 immediately and until first clock after release.
- Cycle N = Nth clock edge after start sampled; LOAD_X in cycle 1.
- add/sub: done in cycle 4 (4 busy cycles).
- mul: done in cycle 2·WIDTH+4.
- div: done in cycle 3·WIDTH+5; divide-by-zero: done+err in cycle 3.
- start high in the cycle done is high is ignored; new start accepted from following IDLE cycle (back-to-back gap ≥1 cycle).
- Counter width $clog2(WIDTH); never exceeds WIDTH-1.

## Configuration
- ALU_SEQ_DIV_EN defined: divide states and sgn flag present, behaviour as above.
- Not defined: DIV_* states, DIV_CORR, sgn absent; op 11 runs LOAD_X, LOAD_Y, then ERR (done+err in cycle 3) regardless of m_zero; c4, c5 always 0.

## Structure
- alu_seq_pkg: state enum, op code localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV), control-bit index localparams C_LOADQ..C_RSV, control word width 11.
- Sub-module alu_seq_iter_counter: modulo-WIDTH counter with inc, clear-on-reset, registered terminal flag last (count==WIDTH-1); successor to the sequence counter.
- FSM, op_r, sgn, output decode in alu_sequencer.

## Test plan
- WIDTH=8, add: inbus 25 then 17 → c8 cycle1, c1 cycle2, c2 cycle3, c6+done cycle4; datapath A=42.
- mul 7·(−3) (0x07, 0xFD) → 8 TEST/SHIFT pairs with correct c2/c3 pattern; done cycle 20; outbus A=0xFF then Q=0xEB.
- div 100/7 → done cycle 29; outbus Q=14 then A=2; DIV_CORR issues c2 only when a_msb=1.
- div with M=0 → ERR in cycle 3, done=err=1, c=0, no c4/c5 ever; busy low cycle 4.
- rst low in cycle 9 of mul → all outputs 0 at once; after release, new add completes in 4 cycles; start pulses during busy ignored.
- Build without ALU_SEQ_DIV_EN, op 11, M=5 → done+err in cycle 3; WIDTH=5 mul 3·3 → done cycle 14, product 9.
